// File: rtl/adx112_scan_seq_if.sv
// Handshake bundle between the ADX112 scan sequencer, the SPI driver beneath it
// and the per-channel sample consumer above it.
interface adx112_scan_seq_if;
    logic        adx112_begin;
    logic        adx112_is_busy;
    logic [15:0] adx112_config_value;
    logic [15:0] adx112_dout;
    logic        adx112_dout_valid;
    logic [15:0] ch_data;
    logic [1:0]  ch_id;
    logic        ch_valid;
    logic        scan_done;
    logic        overrun;

    modport master (
        output adx112_begin,
        output adx112_config_value,
        input  adx112_is_busy,
        input  adx112_dout,
        input  adx112_dout_valid,
        output ch_data,
        output ch_id,
        output ch_valid,
        output scan_done,
        output overrun
    );

    modport slave (
        input  adx112_begin,
        input  adx112_config_value,
        output adx112_is_busy,
        output adx112_dout,
        output adx112_dout_valid,
        input  ch_data,
        input  ch_id,
        input  ch_valid,
        input  scan_done,
        input  overrun
    );
endinterface

// File: rtl/adx112_scan_seq.sv
// Round-robin single-ended channel scanner for the ADX112: one driver transaction
// per sample tick, returned words re-tagged with the channel they belong to.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | scanning off; pairing and overrun cleared
// WAIT_TICK | waiting for the next sample tick
// START     | tick seen; waiting for the driver to be free, then begin
// BUSY      | transaction outstanding; waiting for dout_valid
module adx112_scan_seq #(
    parameter int unsigned CLK_FREQ_MHZ   = 100,
    parameter int unsigned SAMPLE_RATE_HZ = 128,
    parameter logic [3:0]  CH_MASK        = 4'b1111,
    parameter logic [2:0]  PGA            = 3'b001,
    parameter logic [2:0]  DR             = 3'b100
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               enable,
    adx112_scan_seq_if.master  bus
);

    localparam int unsigned PERIOD = CLK_FREQ_MHZ * 1_000_000 / SAMPLE_RATE_HZ;
    localparam int          CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] TC = CNT_W'(PERIOD - 1);

    function automatic logic [1:0] lowest_ch(input logic [3:0] mask);
        lowest_ch = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) lowest_ch = 2'(i);
        end
    endfunction

    function automatic logic [1:0] highest_ch(input logic [3:0] mask);
        highest_ch = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) highest_ch = 2'(i);
        end
    endfunction

    // Smallest offset is evaluated last so it wins; 2-bit add wraps to the lowest.
    function automatic logic [1:0] next_ch(input logic [1:0] cur, input logic [3:0] mask);
        logic [1:0] cand;
        next_ch = cur;
        for (int i = 3; i >= 1; i--) begin
            cand = cur + 2'(i);
            if (mask[cand]) next_ch = cand;
        end
    endfunction

    // SS=1, MUX=1xx (AINn vs GND), single-shot, TS=0, pull-up on, NOP=01, reserved=1.
    function automatic logic [15:0] cfg_word(input logic [1:0] ch);
        cfg_word = {1'b1, 1'b1, ch, PGA, 1'b1, DR, 1'b0, 1'b1, 2'b01, 1'b1};
    endfunction

    localparam logic [1:0] FIRST_CH = lowest_ch(CH_MASK);
    localparam logic [1:0] LAST_CH  = highest_ch(CH_MASK);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_TICK = 2'd1,
        S_START     = 2'd2,
        S_BUSY      = 2'd3
    } state_t;

    state_t            state;
    state_t            nxt_state;
    logic [CNT_W-1:0]  tick_cnt;
    logic              tick;
    logic              leave_idle;
    logic              do_begin;
    logic              do_pair;

    logic [1:0]        cur_ch;
    logic [1:0]        pend_ch;
    logic              pend_valid;

    logic              begin_r;
    logic [15:0]       config_r;
    logic [15:0]       ch_data_r;
    logic [1:0]        ch_id_r;
    logic              ch_valid_r;
    logic              scan_done_r;
    logic              overrun_r;

    // Free-running sample timer, parked at zero whenever scanning is off.
    always_ff @(posedge clk) begin
        if (!rstn || !enable) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TC) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = enable && (tick_cnt == TC);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state  = state;
        leave_idle = 1'b0;
        do_begin   = 1'b0;
        do_pair    = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable && (CH_MASK != 4'b0000)) begin
                    nxt_state  = S_WAIT_TICK;
                    leave_idle = 1'b1;
                end
            end
            S_WAIT_TICK: begin
                if (!enable) begin
                    nxt_state = S_IDLE;
                end else if (tick) begin
                    nxt_state = S_START;
                end
            end
            S_START: begin
                if (!bus.adx112_is_busy) begin
                    do_begin  = 1'b1;
                    nxt_state = S_BUSY;
                end
            end
            S_BUSY: begin
                if (bus.adx112_dout_valid) begin
                    do_pair   = 1'b1;
                    nxt_state = S_WAIT_TICK;
                end
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    // The device answers with the previous conversion, so each returned word
    // belongs to pend_ch, the channel written one transaction earlier.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cur_ch      <= 2'd0;
            pend_ch     <= 2'd0;
            pend_valid  <= 1'b0;
            begin_r     <= 1'b0;
            config_r    <= 16'h0000;
            ch_data_r   <= 16'h0000;
            ch_id_r     <= 2'd0;
            ch_valid_r  <= 1'b0;
            scan_done_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            begin_r     <= do_begin;
            ch_valid_r  <= 1'b0;
            scan_done_r <= 1'b0;

            if (state == S_IDLE) begin
                pend_valid <= 1'b0;
                overrun_r  <= 1'b0;
            end else if (tick && (state == S_START || state == S_BUSY)) begin
                overrun_r <= 1'b1;
            end

            if (leave_idle) begin
                cur_ch <= FIRST_CH;
            end

            if (do_begin) begin
                config_r <= cfg_word(cur_ch);
            end

            if (do_pair) begin
                if (pend_valid) begin
                    ch_valid_r  <= 1'b1;
                    ch_id_r     <= pend_ch;
                    ch_data_r   <= bus.adx112_dout;
                    scan_done_r <= (pend_ch == LAST_CH);
                end
                pend_ch    <= cur_ch;
                pend_valid <= 1'b1;
                cur_ch     <= next_ch(cur_ch, CH_MASK);
            end
        end
    end

    assign bus.adx112_begin        = begin_r;
    assign bus.adx112_config_value = config_r;
    assign bus.ch_data             = ch_data_r;
    assign bus.ch_id               = ch_id_r;
    assign bus.ch_valid            = ch_valid_r;
    assign bus.scan_done           = scan_done_r;
    assign bus.overrun             = overrun_r;

endmodule

// File: tb/tb_adx112_scan_seq.sv
// Bench for adx112_scan_seq: three instances (masks 1111, 0100, 1010) behind a
// simple driver model, checked against a round-robin scoreboard.
module tb_adx112_scan_seq;

    localparam int P = 10;
    localparam logic [11:0] MASKS = {4'b1010, 4'b0100, 4'b1111};

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        en       [3];
    logic        drv_busy [3];
    logic        drv_dv   [3];
    logic [15:0] drv_dout [3];
    int          drv_cnt  [3];

    logic        beg_w  [3];
    logic [15:0] cfg_w  [3];
    logic [15:0] dat_w  [3];
    logic [1:0]  id_w   [3];
    logic        val_w  [3];
    logic        done_w [3];
    logic        ovr_w  [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        adx112_scan_seq_if bus ();
        adx112_scan_seq #(
            .CLK_FREQ_MHZ   (1),
            .SAMPLE_RATE_HZ (100000),
            .CH_MASK        (MASKS[g*4 +: 4]),
            .PGA            (3'b001),
            .DR             (3'b100)
        ) dut (
            .clk    (clk),
            .rstn   (rstn),
            .enable (en[g]),
            .bus    (bus)
        );
        assign bus.adx112_is_busy    = drv_busy[g];
        assign bus.adx112_dout_valid = drv_dv[g];
        assign bus.adx112_dout       = drv_dout[g];
        assign beg_w[g]  = bus.adx112_begin;
        assign cfg_w[g]  = bus.adx112_config_value;
        assign dat_w[g]  = bus.ch_data;
        assign id_w[g]   = bus.ch_id;
        assign val_w[g]  = bus.ch_valid;
        assign done_w[g] = bus.scan_done;
        assign ovr_w[g]  = bus.overrun;
    end

    int n_vec = 0;
    int n_bad = 0;
    int sel = 0;
    int busy_len = 4;
    int stray_done = 0;

    logic [15:0] forced_q [$];
    logic [15:0] sent_q   [$];
    logic [15:0] beg_cfg_q [$];
    int          beg_cyc_q [$];
    logic [1:0]  out_id_q  [$];
    logic [15:0] out_dat_q [$];
    logic        out_done_q [$];

    logic [15:0] exp_cfg_q  [$];
    logic [1:0]  exp_id_q   [$];
    logic [15:0] exp_dat_q  [$];
    logic        exp_done_q [$];

    // Driver model: busy for busy_len cycles after begin, then one dout_valid.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            drv_dv[g] = 1'b0;
            if (beg_w[g] === 1'b1) begin
                drv_busy[g] = 1'b1;
                drv_cnt[g]  = busy_len;
            end else if (drv_busy[g]) begin
                drv_cnt[g] = drv_cnt[g] - 1;
                if (drv_cnt[g] == 0) begin
                    drv_busy[g] = 1'b0;
                    drv_dv[g]   = 1'b1;
                    if (g == sel && forced_q.size() > 0) drv_dout[g] = forced_q.pop_front();
                    else drv_dout[g] = 16'($urandom);
                    if (g == sel) sent_q.push_back(drv_dout[g]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (beg_w[sel] === 1'b1) begin
            beg_cfg_q.push_back(cfg_w[sel]);
            beg_cyc_q.push_back(cyc);
        end
        if (val_w[sel] === 1'b1) begin
            out_id_q.push_back(id_w[sel]);
            out_dat_q.push_back(dat_w[sel]);
            out_done_q.push_back(done_w[sel]);
        end else if (done_w[sel] === 1'b1) begin
            stray_done++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic begin_run(input int s, input int blen);
        sel      = s;
        busy_len = blen;
        forced_q.delete();
        sent_q.delete();
        beg_cfg_q.delete();
        beg_cyc_q.delete();
        out_id_q.delete();
        out_dat_q.delete();
        out_done_q.delete();
    endtask

    task automatic wait_begins(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (beg_cfg_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Scoreboard: channels rotate through the enabled set from the lowest; result j
    // carries the channel of transaction j and the word returned by transaction j+1.
    task automatic build_expected(input logic [3:0] mask);
        int en_list [$];
        int nb;
        int ch;
        int last;
        exp_cfg_q.delete();
        exp_id_q.delete();
        exp_dat_q.delete();
        exp_done_q.delete();
        for (int c = 0; c < 4; c++) if (mask[c]) en_list.push_back(c);
        last = en_list[en_list.size() - 1];
        nb   = beg_cfg_q.size();
        for (int i = 0; i < nb; i++) begin
            ch = en_list[i % en_list.size()];
            exp_cfg_q.push_back({2'b11, 2'(ch), 3'b001, 1'b1, 3'b100, 1'b0, 1'b1, 2'b01, 1'b1});
            if (i + 1 < nb && i + 1 < sent_q.size()) begin
                exp_id_q.push_back(2'(ch));
                exp_dat_q.push_back(sent_q[i + 1]);
                exp_done_q.push_back(ch == last);
            end
        end
    endtask

    task automatic test_reset();
        for (int g = 0; g < 3; g++) en[g] = 1'b0;
        rstn = 1'b0;
        idle(3);
        for (int g = 0; g < 3; g++) begin
            n_vec++;
            if (beg_w[g] !== 1'b0 || cfg_w[g] !== 16'h0000 || dat_w[g] !== 16'h0000 ||
                id_w[g] !== 2'd0 || val_w[g] !== 1'b0 || done_w[g] !== 1'b0 || ovr_w[g] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_outputs[%0d]: got begin %b cfg %h data %h id %0d valid %b done %b ovr %b, need all zero",
                         g, beg_w[g], cfg_w[g], dat_w[g], id_w[g], val_w[g], done_w[g], ovr_w[g]);
            end
        end
        rstn = 1'b1;
        idle(5);
        for (int g = 0; g < 3; g++) begin
            n_vec++;
            if (beg_w[g] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_no_begin[%0d]: got begin %b, need 0 while disabled", g, beg_w[g]);
            end
        end
    endtask

    task automatic test_scan_all();
        bit ok;
        logic [15:0] first_cfg [4] = '{16'hC38B, 16'hD38B, 16'hE38B, 16'hF38B};
        begin_run(0, 4);
        forced_q.push_back(16'($urandom));
        forced_q.push_back(16'h0100);
        forced_q.push_back(16'h0200);
        en[0] = 1'b1;
        wait_begins(9, 200, ok);
        en[0] = 1'b0;
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL scan_all_timeout: got %0d begins, need 9", beg_cfg_q.size());
        end
        idle(30);
        build_expected(4'b1111);
        for (int i = 0; i < 4 && i < beg_cfg_q.size(); i++) begin
            n_vec++;
            if (beg_cfg_q[i] !== first_cfg[i]) begin
                n_bad++;
                $display("FAIL scan_all_cfg_seq[%0d]: got %h, need %h", i, beg_cfg_q[i], first_cfg[i]);
            end
        end
        for (int i = 0; i < beg_cfg_q.size(); i++) begin
            n_vec++;
            if (beg_cfg_q[i] !== exp_cfg_q[i]) begin
                n_bad++;
                $display("FAIL scan_all_cfg[%0d]: got %h, need %h", i, beg_cfg_q[i], exp_cfg_q[i]);
            end
        end
        for (int i = 1; i < beg_cyc_q.size(); i++) begin
            n_vec++;
            if (beg_cyc_q[i] - beg_cyc_q[i-1] != P) begin
                n_bad++;
                $display("FAIL scan_all_spacing[%0d]: got %0d cycles, need %0d", i, beg_cyc_q[i] - beg_cyc_q[i-1], P);
            end
        end
        n_vec++;
        if (out_id_q.size() != exp_id_q.size()) begin
            n_bad++;
            $display("FAIL scan_all_count: got %0d results, need %0d", out_id_q.size(), exp_id_q.size());
        end
        for (int j = 0; j < out_id_q.size() && j < exp_id_q.size(); j++) begin
            n_vec++;
            if (out_id_q[j] !== exp_id_q[j] || out_dat_q[j] !== exp_dat_q[j] || out_done_q[j] !== exp_done_q[j]) begin
                n_bad++;
                $display("FAIL scan_all_result[%0d]: got ch %0d data %h done %b, need ch %0d data %h done %b",
                         j, out_id_q[j], out_dat_q[j], out_done_q[j], exp_id_q[j], exp_dat_q[j], exp_done_q[j]);
            end
        end
        if (out_id_q.size() >= 2) begin
            n_vec++;
            if (out_id_q[0] !== 2'd0 || out_dat_q[0] !== 16'h0100 || out_id_q[1] !== 2'd1 || out_dat_q[1] !== 16'h0200) begin
                n_bad++;
                $display("FAIL scan_all_first_pair: got (%0d,%h) (%0d,%h), need (0,0100) (1,0200)",
                         out_id_q[0], out_dat_q[0], out_id_q[1], out_dat_q[1]);
            end
        end
        n_vec++;
        if (ovr_w[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL scan_all_overrun: got %b, need 0", ovr_w[0]);
        end
    endtask

    task automatic test_single_channel();
        bit ok;
        begin_run(1, 4);
        en[1] = 1'b1;
        wait_begins(6, 200, ok);
        en[1] = 1'b0;
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL single_timeout: got %0d begins, need 6", beg_cfg_q.size());
        end
        idle(30);
        build_expected(4'b0100);
        for (int i = 0; i < beg_cfg_q.size(); i++) begin
            n_vec++;
            if (beg_cfg_q[i] !== 16'hE38B || beg_cfg_q[i] !== exp_cfg_q[i]) begin
                n_bad++;
                $display("FAIL single_cfg[%0d]: got %h, need E38B", i, beg_cfg_q[i]);
            end
        end
        n_vec++;
        if (out_id_q.size() != exp_id_q.size()) begin
            n_bad++;
            $display("FAIL single_count: got %0d results, need %0d", out_id_q.size(), exp_id_q.size());
        end
        for (int j = 0; j < out_id_q.size() && j < exp_id_q.size(); j++) begin
            n_vec++;
            if (out_id_q[j] !== 2'd2 || out_done_q[j] !== 1'b1 || out_dat_q[j] !== exp_dat_q[j]) begin
                n_bad++;
                $display("FAIL single_result[%0d]: got ch %0d data %h done %b, need ch 2 data %h done 1",
                         j, out_id_q[j], out_dat_q[j], out_done_q[j], exp_dat_q[j]);
            end
        end
    endtask

    task automatic test_alternate();
        bit ok;
        begin_run(2, 4);
        en[2] = 1'b1;
        wait_begins(7, 200, ok);
        en[2] = 1'b0;
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL alt_timeout: got %0d begins, need 7", beg_cfg_q.size());
        end
        idle(30);
        build_expected(4'b1010);
        for (int i = 0; i < beg_cfg_q.size(); i++) begin
            n_vec++;
            if (beg_cfg_q[i] !== ((i % 2 == 0) ? 16'hD38B : 16'hF38B)) begin
                n_bad++;
                $display("FAIL alt_cfg[%0d]: got %h, need %h", i, beg_cfg_q[i], (i % 2 == 0) ? 16'hD38B : 16'hF38B);
            end
        end
        n_vec++;
        if (out_id_q.size() != exp_id_q.size()) begin
            n_bad++;
            $display("FAIL alt_count: got %0d results, need %0d", out_id_q.size(), exp_id_q.size());
        end
        for (int j = 0; j < out_id_q.size() && j < exp_id_q.size(); j++) begin
            n_vec++;
            if (out_id_q[j] !== exp_id_q[j] || out_dat_q[j] !== exp_dat_q[j] || out_done_q[j] !== exp_done_q[j]) begin
                n_bad++;
                $display("FAIL alt_result[%0d]: got ch %0d data %h done %b, need ch %0d data %h done %b",
                         j, out_id_q[j], out_dat_q[j], out_done_q[j], exp_id_q[j], exp_dat_q[j], exp_done_q[j]);
            end
        end
        n_vec++;
        if (stray_done != 0) begin
            n_bad++;
            $display("FAIL stray_scan_done: got %0d scan_done pulses without ch_valid, need 0", stray_done);
        end
    endtask

    task automatic test_overrun();
        bit ok;
        begin_run(0, 15);
        en[0] = 1'b1;
        wait_begins(4, 400, ok);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL overrun_timeout: got %0d begins, need 4", beg_cfg_q.size());
        end
        n_vec++;
        if (ovr_w[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_set: got %b, need 1", ovr_w[0]);
        end
        for (int i = 1; i < beg_cyc_q.size(); i++) begin
            n_vec++;
            if (beg_cyc_q[i] - beg_cyc_q[i-1] < 2 * P) begin
                n_bad++;
                $display("FAIL overrun_spacing[%0d]: got %0d cycles, need at least %0d",
                         i, beg_cyc_q[i] - beg_cyc_q[i-1], 2 * P);
            end
        end
        en[0] = 1'b0;
        idle(40);
        build_expected(4'b1111);
        n_vec++;
        if (out_id_q.size() != exp_id_q.size()) begin
            n_bad++;
            $display("FAIL overrun_count: got %0d results, need %0d", out_id_q.size(), exp_id_q.size());
        end
        for (int j = 0; j < out_id_q.size() && j < exp_id_q.size(); j++) begin
            n_vec++;
            if (out_id_q[j] !== exp_id_q[j] || out_dat_q[j] !== exp_dat_q[j]) begin
                n_bad++;
                $display("FAIL overrun_result[%0d]: got ch %0d data %h, need ch %0d data %h",
                         j, out_id_q[j], out_dat_q[j], exp_id_q[j], exp_dat_q[j]);
            end
        end
        n_vec++;
        if (ovr_w[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL overrun_clear: got %b, need 0 after returning to idle", ovr_w[0]);
        end
    endtask

    task automatic test_enable_drop();
        bit ok;
        for (int run = 0; run < 2; run++) begin
            begin_run(0, 4);
            en[0] = 1'b1;
            wait_begins(3, 200, ok);
            en[0] = 1'b0;
            n_vec++;
            if (!ok) begin
                n_bad++;
                $display("FAIL drop_timeout[%0d]: got %0d begins, need 3", run, beg_cfg_q.size());
            end
            idle(40);
            build_expected(4'b1111);
            n_vec++;
            if (beg_cfg_q.size() != 3) begin
                n_bad++;
                $display("FAIL drop_no_more_begin[%0d]: got %0d begins, need 3", run, beg_cfg_q.size());
            end
            n_vec++;
            if (beg_cfg_q.size() > 0 && beg_cfg_q[0] !== 16'hC38B) begin
                n_bad++;
                $display("FAIL drop_restart_cfg[%0d]: got %h, need C38B", run, beg_cfg_q[0]);
            end
            n_vec++;
            if (out_id_q.size() != 2) begin
                n_bad++;
                $display("FAIL drop_count[%0d]: got %0d results, need 2", run, out_id_q.size());
            end
            for (int j = 0; j < out_id_q.size() && j < exp_id_q.size(); j++) begin
                n_vec++;
                if (out_id_q[j] !== exp_id_q[j] || out_dat_q[j] !== exp_dat_q[j]) begin
                    n_bad++;
                    $display("FAIL drop_result[%0d.%0d]: got ch %0d data %h, need ch %0d data %h",
                             run, j, out_id_q[j], out_dat_q[j], exp_id_q[j], exp_dat_q[j]);
                end
            end
        end
    endtask

    task automatic test_reset_in_busy();
        bit ok;
        begin_run(0, 4);
        en[0] = 1'b1;
        wait_begins(1, 100, ok);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL rst_busy_timeout: got %0d begins, need 1", beg_cfg_q.size());
        end
        rstn = 1'b0;
        idle(1);
        n_vec++;
        if (beg_w[0] !== 1'b0 || cfg_w[0] !== 16'h0000 || dat_w[0] !== 16'h0000 ||
            id_w[0] !== 2'd0 || val_w[0] !== 1'b0 || done_w[0] !== 1'b0 || ovr_w[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_busy_outputs: got begin %b cfg %h data %h id %0d valid %b done %b ovr %b, need all zero",
                     beg_w[0], cfg_w[0], dat_w[0], id_w[0], val_w[0], done_w[0], ovr_w[0]);
        end
        rstn = 1'b1;
        out_id_q.delete();
        idle(20);
        n_vec++;
        if (out_id_q.size() != 0) begin
            n_bad++;
            $display("FAIL rst_busy_late_dout: got %0d ch_valid, need 0", out_id_q.size());
        end
        en[0] = 1'b0;
        idle(30);
    endtask

    initial begin
        for (int g = 0; g < 3; g++) begin
            en[g]       = 1'b0;
            drv_busy[g] = 1'b0;
            drv_dv[g]   = 1'b0;
            drv_dout[g] = 16'h0000;
            drv_cnt[g]  = 0;
        end
        rstn = 1'b0;
        test_reset();
        test_scan_all();
        test_single_channel();
        test_alternate();
        test_overrun();
        test_enable_drop();
        test_reset_in_busy();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
